// File: rtl/modport_accel_pkg.sv
// Shared types and sizing helpers for the modport_accel 3x3 convolution engine.
package modport_accel_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_K,
        LOAD_WIN,
        COMPUTE,
        OUTPUT
    } state_t;

    localparam int KERNEL_SIZE = 3;

    function automatic int acc_width(input int data_width);
        return 3 * data_width;
    endfunction

endpackage

// File: rtl/modport_accel_mac9.sv
// Combinational signed 3x3 dot product: kernel taps times window taps, summed at
// full precision and returned sign-extended to 3*DATA_WIDTH bits.
module modport_accel_mac9
    import modport_accel_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] kernel,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] window,
    output logic [acc_width(DATA_WIDTH)-1:0]              result
);

    localparam int ACC_W = acc_width(DATA_WIDTH);
    localparam int TAPS  = KERNEL_SIZE * KERNEL_SIZE;

    logic signed [ACC_W-1:0] sum;

    // Operands are widened to the accumulator width before multiplying so no product bits are lost.
    always_comb begin
        sum = '0;
        for (int t = 0; t < TAPS; t++) begin
            sum = sum + ACC_W'($signed(kernel[t*DATA_WIDTH +: DATA_WIDTH]))
                      * ACC_W'($signed(window[t*DATA_WIDTH +: DATA_WIDTH]));
        end
    end

    assign result = sum;

endmodule

// File: rtl/modport_accel.sv
// Top of the 3x3 convolution accelerator sharing three tri-state buses with the host.
// Define OUTPUT_RELU_EN to clamp negative results to zero before they are presented.
module modport_accel
    import modport_accel_pkg::*;
#(
    parameter int DATA_WIDTH         = 16,
    parameter int FEATURE_MAP_WIDTH  = 8,
    parameter int FEATURE_MAP_HEIGHT = 8,
    parameter int OUTPUT_NB_CHANNELS = 4
) (
    input  logic                                  clk,
    input  logic                                  arst,
    inout  logic [DATA_WIDTH-1:0]                 con_1,
    inout  logic [DATA_WIDTH-1:0]                 con_2,
    inout  logic [DATA_WIDTH-1:0]                 con_3,
    input  logic                                  con_valid,
    output logic                                  con_ready,
    output logic                                  dut_driving_cons,
    output logic                                  last_load_K,
    input  logic                                  start,
    output logic                                  running,
    output logic                                  output_valid,
    output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  output_x,
    output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] output_y,
    output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] output_ch
);

    localparam int ACC_W = acc_width(DATA_WIDTH);
    localparam int ROW_W = KERNEL_SIZE * DATA_WIDTH;
    localparam int KW    = KERNEL_SIZE * ROW_W;
    localparam int XW    = $clog2(FEATURE_MAP_WIDTH);
    localparam int YW    = $clog2(FEATURE_MAP_HEIGHT);
    localparam int CW    = $clog2(OUTPUT_NB_CHANNELS);

    state_t state, state_next;

    logic [KW-1:0]    kernel [OUTPUT_NB_CHANNELS];
    logic [KW-1:0]    window;
    logic [1:0]       row;
    logic [CW-1:0]    ch;
    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] mac_result;

    logic transfer;
    logic last_row;
    logic last_ch;
    logic last_x;
    logic last_y;

    assign transfer = con_valid & con_ready;
    assign last_row = (row == 2'(KERNEL_SIZE - 1));
    assign last_ch  = (ch == CW'(OUTPUT_NB_CHANNELS - 1));
    assign last_x   = (x == XW'(FEATURE_MAP_WIDTH - 1));
    assign last_y   = (y == YW'(FEATURE_MAP_HEIGHT - 1));

    modport_accel_mac9 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mac9 (
        .kernel (kernel[ch]),
        .window (window),
        .result (mac_result)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start) state_next = LOAD_K;
            LOAD_K:   if (transfer && last_row && last_ch) state_next = LOAD_WIN;
            LOAD_WIN: if (transfer && last_row) state_next = COMPUTE;
            COMPUTE:  state_next = OUTPUT;
            OUTPUT: begin
                if (!last_ch) begin
                    state_next = COMPUTE;
                end else if (last_x && last_y) begin
                    state_next = IDLE;
                end else begin
                    state_next = LOAD_WIN;
                end
            end
            default:  state_next = IDLE;
        endcase
    end

    // Row transfers put con_1 in the lowest slot so tap (r, c) lands at flat index r*3 + c.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int c = 0; c < OUTPUT_NB_CHANNELS; c++) begin
                kernel[c] <= '0;
            end
            window <= '0;
            row    <= '0;
            ch     <= '0;
            x      <= '0;
            y      <= '0;
            acc    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        row <= '0;
                        ch  <= '0;
                    end
                end
                LOAD_K: begin
                    if (transfer) begin
                        kernel[ch][int'(row)*ROW_W +: ROW_W] <= {con_3, con_2, con_1};
                        if (last_row) begin
                            row <= '0;
                            if (last_ch) begin
                                ch <= '0;
                                x  <= '0;
                                y  <= '0;
                            end else begin
                                ch <= ch + 1'b1;
                            end
                        end else begin
                            row <= row + 1'b1;
                        end
                    end
                end
                LOAD_WIN: begin
                    if (transfer) begin
                        window[int'(row)*ROW_W +: ROW_W] <= {con_3, con_2, con_1};
                        if (last_row) begin
                            row <= '0;
                            ch  <= '0;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
`ifdef OUTPUT_RELU_EN
                    acc <= mac_result[ACC_W-1] ? '0 : mac_result;
`else
                    acc <= mac_result;
`endif
                end
                OUTPUT: begin
                    if (!last_ch) begin
                        ch <= ch + 1'b1;
                    end else begin
                        ch <= '0;
                        if (last_x) begin
                            x <= '0;
                            y <= last_y ? '0 : y + 1'b1;
                        end else begin
                            x <= x + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign con_ready        = (state == LOAD_K) || (state == LOAD_WIN);
    assign running          = (state != IDLE);
    assign output_valid     = (state == OUTPUT);
    assign dut_driving_cons = (state == OUTPUT);
    assign last_load_K      = (state == LOAD_K) && last_ch && last_row;
    assign output_x         = (state == OUTPUT) ? x  : '0;
    assign output_y         = (state == OUTPUT) ? y  : '0;
    assign output_ch        = (state == OUTPUT) ? ch : '0;

    // The buses are only ever driven in OUTPUT, which never overlaps con_ready.
    assign con_1 = dut_driving_cons ? acc[DATA_WIDTH-1:0]              : 'z;
    assign con_2 = dut_driving_cons ? acc[2*DATA_WIDTH-1:DATA_WIDTH]   : 'z;
    assign con_3 = dut_driving_cons ? acc[3*DATA_WIDTH-1:2*DATA_WIDTH] : 'z;

endmodule

// File: tb/tb_modport_accel.sv
// Scoreboard bench for modport_accel: a host process loads kernels and windows with
// random flow-control gaps while an independent monitor checks every returned result.
module tb_modport_accel;

    localparam int DW = 16;
    localparam int FW = 8;
    localparam int FH = 8;
    localparam int C  = 4;

    logic          clk = 1'b0;
    logic          arst;
    logic          con_valid;
    logic          start;
    logic          host_drive;
    logic [DW-1:0] h1, h2, h3;
    wire  [DW-1:0] con_1, con_2, con_3;
    logic          con_ready;
    logic          dut_driving_cons;
    logic          last_load_K;
    logic          running;
    logic          output_valid;
    logic [2:0]    output_x;
    logic [2:0]    output_y;
    logic [1:0]    output_ch;

    typedef struct {
        logic [3*DW-1:0] val;
        int              x;
        int              y;
        int              ch;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   fails = 0;
    int   outputs_seen = 0;
    int   kern [C][3][3];
    int   win [3][3];

    always #5 clk = ~clk;

    assign con_1 = host_drive ? h1 : 'z;
    assign con_2 = host_drive ? h2 : 'z;
    assign con_3 = host_drive ? h3 : 'z;

    modport_accel #(
        .DATA_WIDTH         (DW),
        .FEATURE_MAP_WIDTH  (FW),
        .FEATURE_MAP_HEIGHT (FH),
        .OUTPUT_NB_CHANNELS (C)
    ) dut (
        .clk              (clk),
        .arst             (arst),
        .con_1            (con_1),
        .con_2            (con_2),
        .con_3            (con_3),
        .con_valid        (con_valid),
        .con_ready        (con_ready),
        .dut_driving_cons (dut_driving_cons),
        .last_load_K      (last_load_K),
        .start            (start),
        .running          (running),
        .output_valid     (output_valid),
        .output_x         (output_x),
        .output_y         (output_y),
        .output_ch        (output_ch)
    );

    function automatic void checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endfunction

    task automatic finishTest();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    endtask

    function automatic int rand16();
        shortint v;
        v = shortint'($urandom);
        return int'(v);
    endfunction

    // Reference convolution straight from the definition, at 64-bit precision.
    function automatic logic [3*DW-1:0] model(input int c);
        longint s = 0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                s += longint'(kern[c][i][j]) * longint'(win[i][j]);
            end
        end
`ifdef OUTPUT_RELU_EN
        if (s < 0) s = 0;
`endif
        return s[3*DW-1:0];
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    always @(negedge clk) begin
        if (!arst) begin
            checkOutput("no_contention", 64'(con_ready & dut_driving_cons), 64'd0);
            if (output_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL unexpected_output: got x=%0d y=%0d ch=%0d, required no output",
                             output_x, output_y, output_ch);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("result", 64'({con_3, con_2, con_1}), 64'(mon_e.val));
                    checkOutput("out_x", 64'(output_x), 64'(mon_e.x));
                    checkOutput("out_y", 64'(output_y), 64'(mon_e.y));
                    checkOutput("out_ch", 64'(output_ch), 64'(mon_e.ch));
                    outputs_seen++;
                end
            end
        end
    end

    // Presents one row only once the DUT is ready; lk returns last_load_K for that slot.
    task automatic applyStimulus(input int a, input int b, input int c, output logic lk);
        int n = 0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        @(negedge clk);
        while (!con_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!con_ready) begin
            checks++;
            fails++;
            $display("[TB] FAIL ready_timeout: got con_ready=0 after %0d cycles, required 1", n);
            finishTest();
        end
        lk         = last_load_K;
        h1         = DW'(a);
        h2         = DW'(b);
        h3         = DW'(c);
        host_drive = 1'b1;
        con_valid  = 1'b1;
        @(posedge clk);
        #1;
        con_valid  = 1'b0;
        host_drive = 1'b0;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_running"}, 64'(running), 64'd0);
        checkOutput({tag, "_con_ready"}, 64'(con_ready), 64'd0);
        checkOutput({tag, "_output_valid"}, 64'(output_valid), 64'd0);
        checkOutput({tag, "_driving"}, 64'(dut_driving_cons), 64'd0);
        checkOutput({tag, "_last_load_K"}, 64'(last_load_K), 64'd0);
        checkOutput({tag, "_coords"}, 64'({output_x, output_y, output_ch}), 64'd0);
    endtask

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("start_running", 64'(running), 64'd1);
        checkOutput("start_load_k_ready", 64'(con_ready), 64'd1);
    endtask

    task automatic loadKernels();
        logic lk;
        for (int c = 0; c < C; c++) begin
            for (int r = 0; r < 3; r++) begin
                applyStimulus(kern[c][r][0], kern[c][r][1], kern[c][r][2], lk);
                checkOutput("last_load_K", 64'(lk), 64'((c == C - 1 && r == 2) ? 1 : 0));
            end
        end
        @(negedge clk);
        checkOutput("ready_after_kernels", 64'(con_ready), 64'd1);
    endtask

    // mode 1: first window is a lone centre 7; mode 2: first window all 3s.
    task automatic runPixels(input int mode, input int stop_pixel);
        logic lk;
        exp_t e;
        int   p;
        int   n;
        outputs_seen = 0;
        for (int y = 0; y < FH; y++) begin
            for (int x = 0; x < FW; x++) begin
                p = y * FW + x;
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        if (p == 0 && mode == 1)      win[i][j] = (i == 1 && j == 1) ? 7 : 0;
                        else if (p == 0 && mode == 2) win[i][j] = 3;
                        else                          win[i][j] = rand16();
                    end
                end
                if (p == 3) begin
                    @(negedge clk);
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                    checkOutput("start_ignored_running", 64'(running), 64'd1);
                end
                for (int r = 0; r < 3; r++) begin
                    applyStimulus(win[r][0], win[r][1], win[r][2], lk);
                    if (p == stop_pixel) return;
                end
                for (int c = 0; c < C; c++) begin
                    e.val = model(c);
                    e.x   = x;
                    e.y   = y;
                    e.ch  = c;
                    sb.push_back(e);
                end
            end
        end
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", 64'(sb.size()), 64'd0);
        @(negedge clk);
        checkOutput("running_after_last", 64'(running), 64'd0);
        checkOutput("output_count", 64'(outputs_seen), 64'(FW * FH * C));
    endtask

    task automatic randomKernels();
        for (int c = 0; c < C; c++)
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    kern[c][i][j] = rand16();
    endtask

    initial begin
        arst       = 1'b1;
        con_valid  = 1'b0;
        start      = 1'b0;
        host_drive = 1'b0;
        h1         = '0;
        h2         = '0;
        h3         = '0;
        repeat (3) @(negedge clk);
        checkReset("init");
        arst = 1'b0;
        @(negedge clk);
        checkOutput("idle_ready", 64'(con_ready), 64'd0);

        // Identity kernel on channel 0.
        randomKernels();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                kern[0][i][j] = (i == 1 && j == 1) ? 1 : 0;
        pulseStart();
        loadKernels();
        runPixels(1, -1);

        // All-negative kernels.
        for (int c = 0; c < C; c++)
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    kern[c][i][j] = -1;
        pulseStart();
        loadKernels();
        runPixels(2, -1);

        // Random run aborted by reset part-way through a window.
        randomKernels();
        pulseStart();
        loadKernels();
        runPixels(0, 1);
        @(negedge clk);
        checkOutput("pre_abort_ready", 64'(con_ready), 64'd1);
        arst = 1'b1;
        #1;
        checkReset("abort");
        repeat (2) @(negedge clk);
        arst = 1'b0;
        sb.delete();
        @(negedge clk);
        checkReset("after_abort");

        // Fresh random run after the abort.
        randomKernels();
        pulseStart();
        loadKernels();
        runPixels(0, -1);

        finishTest();
    end

endmodule

// File: doc/modport_accel.md
Name: modport_accel

Overview:
- Small 3x3 convolution engine with one input channel and OUTPUT_NB_CHANNELS output channels.
- Shares three bidirectional DATA_WIDTH buses (con_1..con_3) with the host.
  - Host drives kernels and input windows onto the buses under a valid/ready handshake.
  - The accelerator turns the buses around to return each 3*DATA_WIDTH result with its (x, y, ch) coordinate.
- Sits between the testbench/host and the datapath; it is the top of the accelerator.

Parameters:
- DATA_WIDTH, 16, width of each con bus; signed two's-complement data.
- FEATURE_MAP_WIDTH, 8, output pixels per row.
- FEATURE_MAP_HEIGHT, 8, output rows.
- OUTPUT_NB_CHANNELS, 4, number of 3x3 kernels / output channels.

Ports:
- clk  in  1  clock, rising edge.
- arst  in  1  asynchronous, active-high reset.
- con_1, con_2, con_3  inout  DATA_WIDTH each  shared buses; the accelerator drives them only while dut_driving_cons=1, otherwise high-Z.
- con_valid  in  1  host data on the con buses is valid.
- con_ready  out  1  accelerator accepts con data this cycle.
- dut_driving_cons  out  1  the accelerator owns the con buses.
- last_load_K  out  1  the current load slot is the final kernel row.
- start  in  1  single-cycle start pulse.
- running  out  1  an operation is in progress.
- output_valid  out  1  a result is on the con buses.
- output_x  out  $clog2(FEATURE_MAP_WIDTH)  column of the result.
- output_y  out  $clog2(FEATURE_MAP_HEIGHT)  row of the result.
- output_ch  out  $clog2(OUTPUT_NB_CHANNELS)  channel of the result.

Behaviour:
- Reset (async, active-high):
  - State IDLE.
  - All outputs 0; buses high-Z.
  - Kernel and window registers and ch/x/y counters cleared.
  - Reset asserted mid-operation aborts immediately.
- Handshake: a transfer occurs on a rising edge with con_valid=1 and con_ready=1. The host holds data while ready=0. con_valid in other states is ignored.
- IDLE: con_ready=0, running=0. start=1 moves to LOAD_K next cycle with running=1. start while running is ignored.
- LOAD_K: con_ready=1.
  - Each transfer stores kernel row r (r=0..2) of channel ch: con_1=column 0, con_2=column 1, con_3=column 2.
  - Order is r fastest, then ch.
  - last_load_K is combinational and high in LOAD_K when ch=C-1 and r=2.
  - After that transfer go to LOAD_WIN with x=y=0.
- LOAD_WIN: con_ready=1.
  - Three transfers give input window rows 0..2 (same column mapping) for output pixel (x, y).
  - The host supplies padding.
  - After the third transfer go to COMPUTE with ch=0.
- COMPUTE (1 cycle, con_ready=0):
  - acc <= sum over i,j of K[ch][i][j]*W[i][j].
  - Full-precision signed arithmetic; result sign-extended to 3*DATA_WIDTH.
  - Then go to OUTPUT.
- OUTPUT (1 cycle):
  - dut_driving_cons=1, output_valid=1, output_x=x, output_y=y, output_ch=ch.
  - Bus mapping: con_1=acc[DW-1:0], con_2=acc[2DW-1:DW], con_3=acc[3DW-1:2DW].
  - Next state:
    - If ch<C-1: ch++ and back to COMPUTE.
    - Else advance the pixel (x++, wrapping to 0 with y++) and go to LOAD_WIN.
    - After pixel (W-1, H-1): go to IDLE, running=0 from the next cycle.
- Throughput: 3 load cycles minimum plus 2*C cycles per pixel.
- dut_driving_cons is 1 only in OUTPUT, so there is no bus contention while con_ready=1.
- Kernels persist until reset. Each start reloads them.

Optional Feature:
- OUTPUT_RELU_EN
  - Defined: acc is clamped to 0 when negative before it is presented in OUTPUT.
  - Undefined: the signed acc is output unchanged.
  - Handshake and timing are identical in both builds.

Decomposition:
- Package modport_accel_pkg holds:
  - state enum {IDLE, LOAD_K, LOAD_WIN, COMPUTE, OUTPUT};
  - KERNEL_SIZE=3;
  - accumulator width function 3*DATA_WIDTH.
- One sub-module, modport_accel_mac9: a combinational signed 9-term dot product taking a 3x3 kernel and a 3x3 window, producing a 3*DATA_WIDTH sign-extended result.

Test Plan:
- Reset check: arst=1 mid-LOAD_WIN -> all outputs 0, buses Z, state IDLE; a following start restarts with LOAD_K.
- Kernel load: C=4, send 12 rows -> last_load_K high only on the 12th slot; con_ready stays 1 through the K-to-window transition.
- Identity arithmetic: K[0] = centre 1, others 0; window centre 7 -> output ch0 value 7 with con_2=con_3=0.
- Negative arithmetic: all K=-1, window all 3 -> acc -27; con_1=0xFFE5, con_2=con_3=0xFFFF (or 0 with OUTPUT_RELU_EN).
- Flow control and ordering: host holds con_valid low for random cycles -> no state advance; outputs appear in ch-major-per-pixel order (x wraps at 7, y increments); running falls after output (7,7,3).
- Bus turnaround: start asserted during running is ignored; bus contention never occurs (con_ready and dut_driving_cons never both 1).
